// File: rtl/stage_if_if.sv
// stage_if_if: bundle of the fetch-stage bus signals.
//   ram_*         instruction RAM request/response (in-order responses)
//   branch_*      redirect request from later pipeline stages
//   id_*          head-of-queue handoff to the decode stage
// The fetch stage uses the master modport; the RAM/decode side uses slave.
interface stage_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ram_ce;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rvalid;
  logic [DATA_W-1:0] ram_data;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;

  modport master (
    output ram_ce, ram_addr, id_valid, id_pc, id_inst,
    input  ram_rvalid, ram_data, branch_en, branch_target, id_ready
  );

  modport slave (
    input  ram_ce, ram_addr, id_valid, id_pc, id_inst,
    output ram_rvalid, ram_data, branch_en, branch_target, id_ready
  );
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction fetch stage with a DEPTH-slot fetch queue.
// Requests are issued to an in-order RAM, responses fill the queue, and the
// decode stage consumes from the head. A redirect empties the queue and
// remembers how many in-flight responses must be thrown away.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active high
//   bus   stage_if_if.master: ram_ce/ram_addr out, ram_rvalid/ram_data in,
//         branch_en/branch_target in, id_valid/id_pc/id_inst out, id_ready in
module stage_if #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  stage_if_if.master bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  drop_q, drop_d;
  logic [ADDR_W-1:0] slot_pc_q [DEPTH];
  logic [ADDR_W-1:0] slot_pc_d [DEPTH];
  logic [DATA_W-1:0] slot_inst_q [DEPTH];
  logic [DATA_W-1:0] slot_inst_d [DEPTH];

  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] outstanding;
  logic [PTR_W:0]   occupancy;
  logic             issue;
  logic             resp_drop;
  logic             resp_take;
  logic             head_valid;
  logic             consume;

  assign used        = alloc_q - head_q;
  assign outstanding = alloc_q - fill_q;
  // Stale responses still owed occupy queue budget: the RAM will deliver
  // them before any new request, so they count against capacity.
  assign occupancy   = {1'b0, used} + {1'b0, drop_q};

  assign issue      = !rst && !bus.branch_en && (occupancy < DEPTH_X);
  assign resp_drop  = bus.ram_rvalid && (drop_q != '0);
  assign resp_take  = bus.ram_rvalid && !bus.branch_en && (drop_q == '0) &&
                      (outstanding != '0);
  assign head_valid = (head_q != fill_q);
  assign consume    = head_valid && bus.id_ready && !bus.branch_en;

  assign bus.ram_ce   = issue;
  assign bus.ram_addr = issue ? pc_q : '0;
  assign bus.id_valid = head_valid;
  assign bus.id_pc    = head_valid ? slot_pc_q[head_q[IDX_W-1:0]] : '0;
  assign bus.id_inst  = head_valid ? slot_inst_q[head_q[IDX_W-1:0]] : '0;

  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    fill_d      = fill_q;
    alloc_d     = alloc_q;
    drop_d      = drop_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;

    if (bus.branch_en) begin
      pc_d   = bus.branch_target;
      head_d = alloc_q;
      fill_d = alloc_q;
      // Everything in flight becomes stale. A response arriving right now is
      // one of those and is discarded here; a response nobody asked for
      // (nothing owed, nothing outstanding) must not underflow the count.
      if (bus.ram_rvalid && ((drop_q != '0) || (outstanding != '0))) begin
        drop_d = drop_q + outstanding - PTR_W'(1);
      end else begin
        drop_d = drop_q + outstanding;
      end
    end else begin
      if (issue) begin
        slot_pc_d[alloc_q[IDX_W-1:0]] = pc_q;
        alloc_d = alloc_q + PTR_W'(1);
        pc_d    = pc_q + ADDR_W'(4);
      end
      if (resp_drop) begin
        drop_d = drop_q - PTR_W'(1);
      end else if (resp_take) begin
        slot_inst_d[fill_q[IDX_W-1:0]] = bus.ram_data;
        fill_d = fill_q + PTR_W'(1);
      end
      if (consume) begin
        head_d = head_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      fill_q  <= '0;
      alloc_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      fill_q      <= fill_d;
      alloc_q     <= alloc_d;
      drop_q      <= drop_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
    end
  end
endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;
  logic clk;
  logic rst_a;
  logic rst_s;
  int   n_checks;
  int   n_errors;
  int   lat;

  stage_if_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  stage_if_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();
  stage_if_if #(.ADDR_W(16), .DATA_W(32)) bus_c ();

  stage_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.master)
  );

  stage_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'hFFF0)) u_dut_b (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_b.master)
  );

  stage_if #(.ADDR_W(16), .DATA_W(32), .DEPTH(8), .RESET_PC(16'hFFE0)) u_dut_c (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_c.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Request history for the main RAM model; entry 0 is the most recent cycle.
  logic        hist_ce   [8] = '{default: 1'b0};
  logic [31:0] hist_addr [8] = '{default: 32'h0};

  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      hist_ce[i]   = hist_ce[i-1];
      hist_addr[i] = hist_addr[i-1];
    end
    hist_ce[0]   = bus_a.ram_ce;
    hist_addr[0] = bus_a.ram_addr;
  end

  // 1-cycle RAMs for the parameter-sweep instances.
  logic        pce_b, pce_c;
  logic [15:0] pad_b, pad_c;
  initial begin
    bus_b.ram_rvalid = 1'b0;
    bus_b.ram_data   = '0;
    bus_c.ram_rvalid = 1'b0;
    bus_c.ram_data   = '0;
    forever begin
      @(negedge clk);
      pce_b = bus_b.ram_ce;
      pad_b = bus_b.ram_addr;
      pce_c = bus_c.ram_ce;
      pad_c = bus_c.ram_addr;
      @(posedge clk);
      #1;
      bus_b.ram_rvalid = pce_b;
      bus_b.ram_data   = pad_b ^ 16'h5A5A;
      bus_c.ram_rvalid = pce_c;
      bus_c.ram_data   = {pad_c, pad_c ^ 16'hA5A5};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge and present the RAM response.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus_a.ram_rvalid = hist_ce[lat-1];
    bus_a.ram_data   = hist_addr[lat-1] ^ 32'hFFFF0000;
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    bus_a.branch_en = 1'b0;
    repeat (5) cyc();
    rst_a = 1'b0;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int count, input int budget);
    logic [31:0] exp_pc;
    int got;
    int n;
    exp_pc = start;
    got = 0;
    n = 0;
    while (got < count && n < budget) begin
      #1;
      if (bus_a.id_valid && bus_a.id_ready && !bus_a.branch_en) begin
        chk("seq_pc", bus_a.id_pc, exp_pc);
        chk("seq_inst", bus_a.id_inst, exp_pc ^ 32'hFFFF0000);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      cyc();
      n++;
    end
    chk("seq_count", got, count);
  endtask

  int          issues;
  logic [15:0] exp_b, exp_c;
  int          cnt_b, cnt_c;
  logic [31:0] pat_b, pat_c;

  initial begin
    n_checks = 0;
    n_errors = 0;
    lat      = 1;
    rst_a    = 1'b1;
    rst_s    = 1'b1;
    bus_a.ram_rvalid    = 1'b0;
    bus_a.ram_data      = '0;
    bus_a.branch_en     = 1'b0;
    bus_a.branch_target = '0;
    bus_a.id_ready      = 1'b1;
    bus_b.branch_en     = 1'b0;
    bus_b.branch_target = '0;
    bus_b.id_ready      = 1'b0;
    bus_c.branch_en     = 1'b0;
    bus_c.branch_target = '0;
    bus_c.id_ready      = 1'b0;

    #2;
    chk("rst_ce", bus_a.ram_ce, 0);
    chk("rst_addr", bus_a.ram_addr, 0);
    chk("rst_valid", bus_a.id_valid, 0);
    chk("rst_pc", bus_a.id_pc, 0);
    chk("rst_inst", bus_a.id_inst, 0);

    // Streaming at one instruction per cycle.
    repeat (3) cyc();
    rst_a = 1'b0;
    #1;
    chk("boot_ce", bus_a.ram_ce, 1);
    chk("boot_addr", bus_a.ram_addr, 0);
    for (int n = 0; n < 8; n++) begin
      #1;
      if (n >= 2) begin
        chk("stream_valid", bus_a.id_valid, 1);
        chk("stream_pc", bus_a.id_pc, 32'(4 * (n - 2)));
        chk("stream_inst", bus_a.id_inst, 32'(4 * (n - 2)) ^ 32'hFFFF0000);
      end
      cyc();
    end

    // Backpressure fills the queue, then drains in order.
    bus_a.id_ready = 1'b0;
    lat = 1;
    do_reset();
    issues = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (bus_a.ram_ce) issues++;
      cyc();
    end
    #1;
    chk("bp_issues", issues, 4);
    chk("bp_full_ce", bus_a.ram_ce, 0);
    chk("bp_valid", bus_a.id_valid, 1);
    chk("bp_head_pc", bus_a.id_pc, 0);
    bus_a.id_ready = 1'b1;
    expect_seq(32'h0, 5, 20);

    // Redirect with three requests in flight, latency 3.
    lat = 3;
    bus_a.id_ready = 1'b1;
    do_reset();
    repeat (3) cyc();
    bus_a.branch_en     = 1'b1;
    bus_a.branch_target = 32'h100;
    #1;
    chk("br_ce", bus_a.ram_ce, 0);
    cyc();
    bus_a.branch_en = 1'b0;
    #1;
    chk("br_empty", bus_a.id_valid, 0);
    chk("br_next_ce", bus_a.ram_ce, 1);
    chk("br_next_addr", bus_a.ram_addr, 32'h100);
    expect_seq(32'h100, 3, 20);

    // Redirect colliding with a response, a consume request and a full queue.
    lat = 3;
    bus_a.id_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    #1;
    chk("col_full_ce", bus_a.ram_ce, 0);
    chk("col_valid", bus_a.id_valid, 1);
    chk("col_rvalid", bus_a.ram_rvalid, 1);
    bus_a.id_ready      = 1'b1;
    bus_a.branch_en     = 1'b1;
    bus_a.branch_target = 32'h200;
    cyc();
    bus_a.branch_en = 1'b0;
    #1;
    chk("col_empty", bus_a.id_valid, 0);
    chk("col_drop", u_dut.drop_q, 2);
    chk("col_ce", bus_a.ram_ce, 1);
    chk("col_addr", bus_a.ram_addr, 32'h200);
    expect_seq(32'h200, 3, 20);

    // Asynchronous reset mid-stream with two requests outstanding.
    lat = 2;
    bus_a.id_ready = 1'b1;
    do_reset();
    repeat (5) cyc();
    #1;
    chk("ar_pre_valid", bus_a.id_valid, 1);
    chk("ar_pre_pc", bus_a.id_pc, 32'h8);
    #1;
    rst_a = 1'b1;
    #1;
    chk("ar_ce", bus_a.ram_ce, 0);
    chk("ar_addr", bus_a.ram_addr, 0);
    chk("ar_valid", bus_a.id_valid, 0);
    chk("ar_pc", bus_a.id_pc, 0);
    chk("ar_inst", bus_a.id_inst, 0);
    cyc();
    rst_a = 1'b0;
    #1;
    chk("ar_late_rvalid", bus_a.ram_rvalid, 1);
    chk("ar_restart_ce", bus_a.ram_ce, 1);
    chk("ar_restart_addr", bus_a.ram_addr, 0);
    expect_seq(32'h0, 3, 20);

    // Parameter sweep: DEPTH=2 and DEPTH=8 with 16-bit addresses near the top.
    pat_b = 32'hB3C7_5A69;
    pat_c = 32'h6D2E_97F1;
    exp_b = 16'hFFF0;
    exp_c = 16'hFFE0;
    cnt_b = 0;
    cnt_c = 0;
    cyc();
    rst_s = 1'b0;
    #1;
    chk("b_boot_addr", bus_b.ram_addr, 16'hFFF0);
    chk("c_boot_addr", bus_c.ram_addr, 16'hFFE0);
    for (int n = 0; n < 72; n++) begin
      if (n < 40) begin
        bus_b.id_ready = pat_b[n % 32];
        bus_c.id_ready = pat_c[n % 32];
      end else if (n < 52) begin
        bus_b.id_ready = 1'b0;
        bus_c.id_ready = 1'b0;
      end else begin
        bus_b.id_ready = 1'b1;
        bus_c.id_ready = 1'b1;
      end
      #1;
      if (n == 52) begin
        chk("b_full_ce", bus_b.ram_ce, 0);
        chk("c_full_ce", bus_c.ram_ce, 0);
        chk("b_full_valid", bus_b.id_valid, 1);
        chk("c_full_valid", bus_c.id_valid, 1);
        chk("b_full_pc", bus_b.id_pc, exp_b);
        chk("c_full_pc", bus_c.id_pc, exp_c);
      end
      if (bus_b.id_valid && bus_b.id_ready) begin
        chk("b_pc", bus_b.id_pc, exp_b);
        chk("b_inst", bus_b.id_inst, exp_b ^ 16'h5A5A);
        exp_b = exp_b + 16'd4;
        cnt_b++;
      end
      if (bus_c.id_valid && bus_c.id_ready) begin
        chk("c_pc", bus_c.id_pc, exp_c);
        chk("c_inst", bus_c.id_inst, {exp_c, exp_c ^ 16'hA5A5});
        exp_c = exp_c + 16'd4;
        cnt_c++;
      end
      cyc();
    end
    chk("b_wrapped", (cnt_b >= 12), 1);
    chk("c_wrapped", (cnt_c >= 12), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
